mem_port_ctrl: RTL and testbench
================================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, word width; TIMEOUT_CYCLES, 255, max cycles waiting for rsp_valid (1..255).
REQ-002 Ports SHALL be (name direction width meaning):
- clk input 1 system clock.
- reset input 1 asynchronous active-low reset.
- mem_read input 1 read request from the control unit.
- mem_write input 1 write request from the control unit.
- i_or_d input 1 address select: 0 = pc, 1 = alu_out.
- pc input DATA_WIDTH instruction address.
- alu_out input DATA_WIDTH data address.
- write_data input DATA_WIDTH store data.
- req_valid output 1 memory request valid.
- req_ready input 1 memory accepts request.
- req_we output 1 request is a write.
- req_addr output DATA_WIDTH request address.
- req_wdata output DATA_WIDTH request write data.
- rsp_valid input 1 memory response valid.
- rsp_rdata input DATA_WIDTH read data.
- mdr output DATA_WIDTH memory data register.
- mem_done output 1 one-cycle pulse: access complete.
- busy output 1 access in progress.
- mem_err output 1 sticky error flag.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT_RSP, DONE, ERR.
- IDLE: on mem_read or mem_write high, latch address (per i_or_d), write_data and direction; go to REQ.
- REQ: req_valid=1; stay until req_ready; then go to WAIT_RSP.
- WAIT_RSP: on rsp_valid, go to DONE, loading mdr from rsp_rdata on reads only.
- DONE: mem_done=1 for exactly one cycle; return to IDLE.
- ERR: terminal until reset.
REQ-004 mem_read and mem_write both high in IDLE SHALL set mem_err and go to ERR; no request is issued.
REQ-005 req_addr, req_we and req_wdata SHALL come from the latched registers and stay stable while req_valid=1.
REQ-006 Input changes after the latch cycle SHALL NOT affect the request in flight.
REQ-007 busy SHALL be 1 in REQ and WAIT_RSP, and 0 otherwise.
REQ-008 Minimum latency SHALL be 3 cycles (IDLE to mem_done) when req_ready and rsp_valid are both high.
REQ-009 An 8-bit timeout counter SHALL clear on entering REQ and increment each cycle in REQ and WAIT_RSP.
- Reaching TIMEOUT_CYCLES SHALL set mem_err and go to ERR.
REQ-010 When rsp_valid and the timeout coincide, rsp_valid SHALL win (go to DONE).
REQ-011 rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-012 mdr SHALL hold its value except on a read completion.
REQ-013 mem_read or mem_write high during REQ, WAIT_RSP or DONE SHALL be ignored (no queuing).

Reset
REQ-014 reset low SHALL asynchronously force state IDLE, zero all registers and outputs (mdr=0, mem_err=0), including mid-access.

Configuration
REQ-015 With MEM_MISALIGN_CHECK_EN defined, a latched address with bits[1:0]≠0 SHALL set mem_err and go to ERR instead of REQ.
- Without it, addresses SHALL pass through unchecked.

Structure
REQ-016 The state encoding and the TIMEOUT width constant SHALL reside in the shared package with the opcode definitions.
REQ-017 The timeout counter SHALL be a sub-module named mem_timeout_cnt.

Verification
REQ-018 Read, i_or_d=0, pc=0x40, memory ready immediately with rsp_rdata=0xDEADBEEF -> req_addr=0x40, req_we=0, mdr=0xDEADBEEF, mem_done pulses 3 cycles after the request.
REQ-019 Write, i_or_d=1, alu_out=0x100, write_data=0x12345678, req_ready delayed 4 cycles -> req fields stable for 4 cycles, req_we=1, mdr unchanged.
REQ-020 rsp_valid withheld with TIMEOUT_CYCLES=10 -> mem_err=1 and state ERR exactly 10 cycles after entering REQ; no mem_done.
REQ-021 mem_read and mem_write high together -> mem_err=1, req_valid never asserted.
REQ-022 reset low during WAIT_RSP -> outputs zero immediately; a read after reset completes normally.
REQ-023 With MEM_MISALIGN_CHECK_EN, address 0x102 -> mem_err=1; without it, req_addr=0x102 is issued.

Source files
------------

// File: rtl/mem_port_ctrl_pkg.sv
// Shared types for the memory port controller: FSM states, access opcodes
// and the timeout counter width.
package mem_port_ctrl_pkg;

    localparam int unsigned TO_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE     = 2'b00,
        OP_READ     = 2'b01,
        OP_WRITE    = 2'b10,
        OP_CONFLICT = 2'b11
    } mem_op_e;

    function automatic mem_op_e decode_op(input logic rd, input logic wr);
        mem_op_e op;
        case ({wr, rd})
            2'b01:   op = OP_READ;
            2'b10:   op = OP_WRITE;
            2'b11:   op = OP_CONFLICT;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Access timeout counter: cleared when a request starts, counts every active
// cycle and flags expiry once TIMEOUT_CYCLES active cycles have elapsed.
module mem_timeout_cnt
    import mem_port_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {TO_W{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + TO_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {TO_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This cycle is the last one allowed, so the next edge must leave.
    assign expired = en && (cnt_q >= TO_W'(TIMEOUT_CYCLES - 32'd1));

endmodule

// File: rtl/mem_port_ctrl.sv
// Multicycle-CPU memory port controller: latches a read/write access and runs
// a valid/ready request plus response handshake. Optional MEM_MISALIGN_CHECK_EN
// traps word-misaligned addresses.
module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  i_or_d,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_we,
    output logic [DATA_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [DATA_WIDTH-1:0] mdr,
    output logic                  mem_done,
    output logic                  busy,
    output logic                  mem_err
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic                  req_valid_q, req_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] lat_addr_s;
    logic                  misalign_s;
    mem_op_e               op_s;
    logic                  tmo_clr_s;
    logic                  tmo_en_s;
    logic                  tmo_exp_s;

    mem_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmo_clr_s),
        .en     (tmo_en_s),
        .expired(tmo_exp_s)
    );

    // Next-state, latch and registered-output decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        mdr_d      = mdr_q;
        lat_addr_s = i_or_d ? alu_out : pc;
        op_s       = decode_op(mem_read, mem_write);
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_s = (lat_addr_s[1:0] != 2'b00);
`else
        misalign_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                case (op_s)
                    OP_READ, OP_WRITE: begin
                        addr_d  = lat_addr_s;
                        wdata_d = write_data;
                        we_d    = (op_s == OP_WRITE);
                        if (misalign_s) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                    OP_CONFLICT: state_d = ST_ERR;
                    default:     state_d = ST_IDLE;
                endcase
            end
            ST_REQ: begin
                if (req_ready) begin
                    state_d = ST_WAIT_RSP;
                end else if (tmo_exp_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT_RSP: begin
                // A response arriving on the expiry cycle still completes.
                if (rsp_valid) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        mdr_d = rsp_rdata;
                    end else begin
                        mdr_d = mdr_q;
                    end
                end else if (tmo_exp_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase

        req_valid_d = (state_d == ST_REQ);
        busy_d      = (state_d == ST_REQ) || (state_d == ST_WAIT_RSP);
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
        tmo_clr_s   = (state_q == ST_IDLE) && (state_d == ST_REQ);
        tmo_en_s    = (state_q == ST_REQ) || (state_q == ST_WAIT_RSP);
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= {DATA_WIDTH{1'b0}};
            wdata_q     <= {DATA_WIDTH{1'b0}};
            we_q        <= 1'b0;
            mdr_q       <= {DATA_WIDTH{1'b0}};
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            mdr_q       <= mdr_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_we    = we_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
    assign mdr       = mdr_q;
    assign mem_done  = done_q;
    assign busy      = busy_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed self-checking bench for mem_port_ctrl (built with TIMEOUT_CYCLES=10).
module tb_mem_port_ctrl;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          mem_read;
    logic          mem_write;
    logic          i_or_d;
    logic [DW-1:0] pc;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] write_data;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [DW-1:0] mdr;
    logic          mem_done;
    logic          busy;
    logic          mem_err;

    int n_checks;
    int n_fail;

    mem_port_ctrl #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .i_or_d    (i_or_d),
        .pc        (pc),
        .alu_out   (alu_out),
        .write_data(write_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mdr       (mdr),
        .mem_done  (mem_done),
        .busy      (busy),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset;
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %0b want 0", req_valid); end
        n_checks++; if (mdr !== 32'h0) begin n_fail++; $display("FAIL rst_mdr: got %h want 0", mdr); end
        n_checks++; if ({mem_done, busy, mem_err, req_we} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {mem_done, busy, mem_err, req_we}); end
        n_checks++; if (req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", req_addr); end
    endtask

    task automatic test_read;
        i_or_d = 1'b0; pc = 32'h40; mem_read = 1'b1;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'hDEADBEEF;
        tick;
        mem_read = 1'b0;
        n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL rd_req_valid: got %0b want 1", req_valid); end
        n_checks++; if (req_addr !== 32'h40) begin n_fail++; $display("FAIL rd_addr: got %h want 00000040", req_addr); end
        n_checks++; if (req_we !== 1'b0) begin n_fail++; $display("FAIL rd_we: got %0b want 0", req_we); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %0b want 1", busy); end
        tick;
        n_checks++; if ({req_valid, mem_done, busy} !== 3'b001) begin n_fail++; $display("FAIL rd_wait: got %b want 001", {req_valid, mem_done, busy}); end
        tick;
        n_checks++; if (mem_done !== 1'b1) begin n_fail++; $display("FAIL rd_done: got %0b want 1", mem_done); end
        n_checks++; if (mdr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_mdr: got %h want deadbeef", mdr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_done_busy: got %0b want 0", busy); end
        tick;
        n_checks++; if (mem_done !== 1'b0) begin n_fail++; $display("FAIL rd_done_pulse: got %0b want 0", mem_done); end
        rsp_valid = 1'b0; req_ready = 1'b0;
    endtask

    task automatic test_write;
        mem_write = 1'b1; i_or_d = 1'b1; alu_out = 32'h100; write_data = 32'h12345678;
        pc = 32'h44; req_ready = 1'b0; rsp_valid = 1'b0;
        tick;
        mem_write = 1'b0; alu_out = 32'hFFF0; write_data = 32'h0; mem_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL wr_req_valid[%0d]: got %0b want 1", i, req_valid); end
            n_checks++; if (req_addr !== 32'h100) begin n_fail++; $display("FAIL wr_addr[%0d]: got %h want 00000100", i, req_addr); end
            n_checks++; if (req_wdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_wdata[%0d]: got %h want 12345678", i, req_wdata); end
            n_checks++; if (req_we !== 1'b1) begin n_fail++; $display("FAIL wr_we[%0d]: got %0b want 1", i, req_we); end
            if (i == 1) mem_read = 1'b0;
            if (i == 3) req_ready = 1'b1;
            tick;
        end
        n_checks++; if ({req_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL wr_wait: got %b want 01", {req_valid, busy}); end
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hAAAA5555;
        tick;
        rsp_valid = 1'b0;
        n_checks++; if (mem_done !== 1'b1) begin n_fail++; $display("FAIL wr_done: got %0b want 1", mem_done); end
        n_checks++; if (mdr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mdr_hold: got %h want deadbeef", mdr); end
        tick;
        n_checks++; if ({req_valid, busy, mem_done} !== 3'b000) begin n_fail++; $display("FAIL wr_no_queue: got %b want 000", {req_valid, busy, mem_done}); end
    endtask

    task automatic test_timeout;
        i_or_d = 1'b0; pc = 32'h80; mem_read = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0;
        tick;
        mem_read = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (k < 10) begin
                n_checks++; if ({mem_err, busy} !== 2'b01) begin n_fail++; $display("FAIL tmo_early[%0d]: got err,busy=%b want 01", k, {mem_err, busy}); end
            end else begin
                n_checks++; if ({mem_err, busy} !== 2'b10) begin n_fail++; $display("FAIL tmo_expire: got err,busy=%b want 10", {mem_err, busy}); end
            end
            n_checks++; if (mem_done !== 1'b0) begin n_fail++; $display("FAIL tmo_done[%0d]: got %0b want 0", k, mem_done); end
        end
        req_ready = 1'b0; mem_read = 1'b1;
        repeat (3) tick;
        mem_read = 1'b0;
        n_checks++; if ({req_valid, mem_err} !== 2'b01) begin n_fail++; $display("FAIL err_terminal: got %b want 01", {req_valid, mem_err}); end
        apply_reset;
    endtask

    task automatic test_conflict;
        pc = 32'h0; i_or_d = 1'b0; mem_read = 1'b1; mem_write = 1'b1; req_ready = 1'b1;
        tick;
        mem_read = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({req_valid, mem_err} !== 2'b01) begin n_fail++; $display("FAIL conflict[%0d]: got %b want 01", i, {req_valid, mem_err}); end
            tick;
        end
        req_ready = 1'b0;
        apply_reset;
    endtask

    task automatic test_reset_mid;
        i_or_d = 1'b0; pc = 32'h10; mem_read = 1'b1;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h11112222;
        tick; mem_read = 1'b0; tick; tick;
        n_checks++; if (mdr !== 32'h11112222) begin n_fail++; $display("FAIL mid_pre_mdr: got %h want 11112222", mdr); end
        tick;
        pc = 32'h30; mem_read = 1'b1; rsp_valid = 1'b0;
        tick; mem_read = 1'b0; tick;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %0b want 1", busy); end
        reset = 1'b0;
        #1;
        n_checks++; if ({busy, req_valid, mem_err, mem_done} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_flags: got %b want 0000", {busy, req_valid, mem_err, mem_done}); end
        n_checks++; if (mdr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_mdr: got %h want 0", mdr); end
        n_checks++; if (req_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_addr: got %h want 0", req_addr); end
        tick;
        reset = 1'b1;
        pc = 32'h20; mem_read = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h0BADF00D;
        tick; mem_read = 1'b0;
        n_checks++; if (req_addr !== 32'h20) begin n_fail++; $display("FAIL post_rst_addr: got %h want 00000020", req_addr); end
        tick; tick;
        n_checks++; if ({mem_done, mdr} !== {1'b1, 32'h0BADF00D}) begin n_fail++; $display("FAIL post_rst_read: got done=%0b mdr=%h want 1 0badf00d", mem_done, mdr); end
        tick;
        rsp_valid = 1'b0; req_ready = 1'b0;
    endtask

    task automatic test_misalign;
        i_or_d = 1'b1; alu_out = 32'h102; mem_read = 1'b1;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h5A5A5A5A;
        tick;
        mem_read = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        n_checks++; if ({req_valid, mem_err} !== 2'b01) begin n_fail++; $display("FAIL misalign_trap: got %b want 01", {req_valid, mem_err}); end
        apply_reset;
`else
        n_checks++; if ({req_valid, mem_err} !== 2'b10) begin n_fail++; $display("FAIL misalign_pass: got %b want 10", {req_valid, mem_err}); end
        n_checks++; if (req_addr !== 32'h102) begin n_fail++; $display("FAIL misalign_addr: got %h want 00000102", req_addr); end
        tick; tick;
        n_checks++; if ({mem_done, mdr} !== {1'b1, 32'h5A5A5A5A}) begin n_fail++; $display("FAIL misalign_read: got done=%0b mdr=%h want 1 5a5a5a5a", mem_done, mdr); end
        tick;
`endif
        rsp_valid = 1'b0; req_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; i_or_d = 1'b0;
        pc = 32'h0; alu_out = 32'h0; write_data = 32'h0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
        test_reset;
        test_read;
        test_write;
        test_timeout;
        test_conflict;
        test_reset_mid;
        test_misalign;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
